// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: frame/button/datapath signals between the pong game sequencer and its surroundings
//   master: the sequencer (consumes frame_tick, btn_start, ball_miss, paddle_hit; drives the rest)
//   slave : the VGA timing / datapath side
interface pong_game_ctrl_if;
   logic       frame_tick;
   logic       btn_start;
   logic       ball_miss;
   logic       paddle_hit;
   logic       game_enable;
   logic       dp_rst_n;
   logic [7:0] score;
   logic [1:0] lives;
   logic [2:0] state;
   logic       game_over;
   modport master (
      input  frame_tick, btn_start, ball_miss, paddle_hit,
      output game_enable, dp_rst_n, score, lives, state, game_over
   );
   modport slave (
      output frame_tick, btn_start, ball_miss, paddle_hit,
      input  game_enable, dp_rst_n, score, lives, state, game_over
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame match sequencer (IDLE/SERVE/PLAY/POINT/OVER) driving the pong datapath
//   clk, rst_n (async active-low)
//   bus.frame_tick/btn_start/ball_miss/paddle_hit in; bus.game_enable/dp_rst_n/score/lives/state/game_over out
module pong_game_ctrl #(
   parameter int LIVES         = 3,
   parameter int SERVE_FRAMES  = 60,
   parameter int POINT_FRAMES  = 30,
   parameter int SPEEDUP_SCORE = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   pong_game_ctrl_if.master   bus
);
   localparam int CW = 16;
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
   state_t          st;
   logic [7:0]      score_r;
   logic [1:0]      lives_r;
   logic [CW-1:0]   cnt;
   logic            start_q, hit_q, armed, parity, en_r, dp_r, over_r;
   logic            start_edge, hit_edge;
   // armed only sets once the button has been seen released, so a press held through reset never starts a game
   assign start_edge = armed & bus.btn_start & ~start_q;
   assign hit_edge   = bus.paddle_hit & ~hit_q;
   assign bus.game_enable = en_r;
   assign bus.dp_rst_n    = dp_r;
   assign bus.score       = score_r;
   assign bus.lives       = lives_r;
   assign bus.state       = st;
   assign bus.game_over   = over_r;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st      <= IDLE;
         score_r <= '0;
         lives_r <= 2'(LIVES);
         cnt     <= '0;
         start_q <= 1'b0;
         hit_q   <= 1'b0;
         armed   <= 1'b0;
         parity  <= 1'b0;
         en_r    <= 1'b0;
         dp_r    <= 1'b0;
         over_r  <= 1'b0;
      end else begin
         start_q <= bus.btn_start;
         hit_q   <= bus.paddle_hit;
         en_r    <= 1'b0;
         if (!bus.btn_start) armed <= 1'b1;
         case (st)
            IDLE, OVER:
               if (start_edge) begin
                  st      <= SERVE;
                  score_r <= '0;
                  lives_r <= 2'(LIVES);
                  cnt     <= CW'(SERVE_FRAMES);
                  dp_r    <= 1'b0;
                  over_r  <= 1'b0;
               end
            SERVE:
               if (bus.frame_tick) begin
                  if (cnt == CW'(1)) begin
                     st     <= PLAY;
                     parity <= 1'b0;
                     dp_r   <= 1'b1;
                  end else cnt <= cnt - CW'(1);
               end
            PLAY:
               // a miss wins over a same-cycle hit and suppresses the step pulse
               if (bus.ball_miss) begin
                  if (lives_r == 2'd1) begin
                     lives_r <= 2'd0;
                     st      <= OVER;
                     over_r  <= 1'b1;
                  end else begin
                     lives_r <= lives_r - 2'd1;
                     st      <= POINT;
                     cnt     <= CW'(POINT_FRAMES);
                     dp_r    <= 1'b0;
                  end
               end else begin
                  if (hit_edge && score_r != 8'hff) score_r <= score_r + 8'd1;
                  if (bus.frame_tick) begin
                     parity <= ~parity;
                     en_r   <= (int'(score_r) >= SPEEDUP_SCORE) | ~parity;
                  end
               end
            POINT:
               if (bus.frame_tick) begin
                  if (cnt == CW'(1)) begin
                     st  <= SERVE;
                     cnt <= CW'(SERVE_FRAMES);
                  end else cnt <= cnt - CW'(1);
               end
            default: st <= IDLE;
         endcase
      end
endmodule
